// File: rtl/clock_time_keeper_pkg.sv
// clock_pkg: shared BCD widths, display codes, field limits and FSM states
package clock_pkg;
   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] DIGIT_DASH = 4'hF;
   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX = 59;
   localparam int SEC_MAX = 59;
   typedef logic [BCD_W-1:0] bcd_t;
   typedef enum logic [1:0] {ST_RUN, ST_SET_HOUR, ST_SET_MIN} state_t;
   function automatic logic bcd_is_max(input bcd_t t, input bcd_t u, input int max);
      return t == bcd_t'(max / 10) && u == bcd_t'(max % 10);
   endfunction
   function automatic logic [2*BCD_W-1:0] bcd_inc(input bcd_t t, input bcd_t u, input int max);
      return bcd_is_max(t, u, max) ? '0 : u == bcd_t'(9) ? {t + bcd_t'(1), bcd_t'(0)} : {t, u + bcd_t'(1)};
   endfunction
endpackage

// File: rtl/clock_time_keeper_if.sv
// clock_time_keeper_if: button inputs and display/status outputs of the time keeper
interface clock_time_keeper_if;
   import clock_pkg::*;
   logic btn_mode;
   logic btn_inc;
   bcd_t dig0;
   bcd_t dig1;
   bcd_t dig2;
   bcd_t dig3;
   logic sec_pulse;
   logic setting;
   modport master (output btn_mode, btn_inc, input dig0, dig1, dig2, dig3, sec_pulse, setting);
   modport slave (input btn_mode, btn_inc, output dig0, dig1, dig2, dig3, sec_pulse, setting);
endinterface

// File: rtl/clock_time_keeper_button_conditioner.sv
// button_conditioner: 2-flop synchroniser, stable-level debounce and single-cycle press strobe
module button_conditioner #(
   parameter int DEBOUNCE_CYC = 20_000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_btn,
   output logic o_press
);
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_press;
   logic          w_done;
   assign w_done = r_cnt == CW'(DEBOUNCE_CYC - 1);
   assign o_press = r_press;
   // accept a new level once it has differed from the accepted one for DEBOUNCE_CYC cycles
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_btn};
         r_press <= 1'b0;
         if (r_sync[1] == r_level) r_cnt <= '0;
         else if (w_done) begin
            r_cnt   <= '0;
            r_level <= r_sync[1];
            r_press <= r_sync[1];
         end else r_cnt <= r_cnt + CW'(1);
      end
endmodule

// File: rtl/clock_time_keeper.sv
// clock_time_keeper: 1 Hz prescaler, 24 h BCD time and two-button hour/minute set mode
module clock_time_keeper import clock_pkg::*; #(
   parameter int CLK_HZ = 1_000_000,
   parameter int DEBOUNCE_CYC = 20_000
) (
   input  logic                clock,
   input  logic                reset_n,
   clock_time_keeper_if.slave  bus
);
   localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [PW-1:0] r_pre;
   bcd_t          r_hh_t, r_hh_u, r_mm_t, r_mm_u, r_ss_t, r_ss_u;
   bcd_t          r_dig0, r_dig1, r_dig2, r_dig3;
   logic          r_sec_pulse, r_setting;
   logic          w_mode, w_inc, w_tick, w_run, w_blank_h, w_blank_m, w_sec_max, w_min_max;
   button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
      .clock(clock), .reset_n(reset_n), .i_btn(bus.btn_mode), .o_press(w_mode));
   button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc (
      .clock(clock), .reset_n(reset_n), .i_btn(bus.btn_inc), .o_press(w_inc));
   assign w_tick    = r_pre == PW'(CLK_HZ - 1);
   assign w_run     = r_state == ST_RUN;
   assign w_blank_h = r_state == ST_SET_HOUR && r_pre >= PW'(CLK_HZ / 2);
   assign w_blank_m = r_state == ST_SET_MIN && r_pre >= PW'(CLK_HZ / 2);
   assign w_sec_max = bcd_is_max(r_ss_t, r_ss_u, SEC_MAX);
   assign w_min_max = bcd_is_max(r_mm_t, r_mm_u, MIN_MAX);
   assign bus.dig0      = r_dig0;
   assign bus.dig1      = r_dig1;
   assign bus.dig2      = r_dig2;
   assign bus.dig3      = r_dig3;
   assign bus.sec_pulse = r_sec_pulse;
   assign bus.setting   = r_setting;
   // mode strobe steps RUN -> SET_HOUR -> SET_MIN -> RUN
   always_comb begin
      w_state_nxt = r_state;
      if (w_mode) w_state_nxt = w_run ? ST_SET_HOUR : r_state == ST_SET_HOUR ? ST_SET_MIN : ST_RUN;
   end
   // state register; reset aborts any set mode
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) r_state <= ST_RUN;
      else r_state <= w_state_nxt;
   // prescaler restarts on entering SET_HOUR and on returning to RUN, otherwise wraps at CLK_HZ-1
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) r_pre <= '0;
      else if ((w_mode && r_state != ST_SET_HOUR) || w_tick) r_pre <= '0;
      else r_pre <= r_pre + PW'(1);
   // time fields: seconds count in RUN, hours/minutes adjusted in set mode; mode beats tick and inc
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) {r_hh_t, r_hh_u, r_mm_t, r_mm_u, r_ss_t, r_ss_u} <= '0;
      else if (w_mode) begin
         if (w_run) {r_ss_t, r_ss_u} <= '0;
      end else if (w_run && w_tick) begin
         {r_ss_t, r_ss_u} <= bcd_inc(r_ss_t, r_ss_u, SEC_MAX);
         if (w_sec_max) {r_mm_t, r_mm_u} <= bcd_inc(r_mm_t, r_mm_u, MIN_MAX);
         if (w_sec_max && w_min_max) {r_hh_t, r_hh_u} <= bcd_inc(r_hh_t, r_hh_u, HOUR_MAX);
      end else if (w_inc && r_state == ST_SET_HOUR) {r_hh_t, r_hh_u} <= bcd_inc(r_hh_t, r_hh_u, HOUR_MAX);
      else if (w_inc && r_state == ST_SET_MIN) {r_mm_t, r_mm_u} <= bcd_inc(r_mm_t, r_mm_u, MIN_MAX);
   // registered outputs; the field being set shows dashes during the upper half of each second
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         {r_dig0, r_dig1, r_dig2, r_dig3} <= '0;
         r_sec_pulse <= 1'b0;
         r_setting   <= 1'b0;
      end else begin
         r_dig0      <= w_blank_h ? DIGIT_DASH : r_hh_t;
         r_dig1      <= w_blank_h ? DIGIT_DASH : r_hh_u;
         r_dig2      <= w_blank_m ? DIGIT_DASH : r_mm_t;
         r_dig3      <= w_blank_m ? DIGIT_DASH : r_mm_u;
         r_sec_pulse <= w_run && w_tick && !w_mode;
         r_setting   <= !w_run;
      end
endmodule
